// File: rtl/stereo_serializer.sv
// rtl/stereo_serializer.sv - left-justified stereo serializer with a single-entry holding buffer
// Build option: define SERIALIZER_MUTE_ON_UNDERRUN_EN to send silence (L=R=0) on underrun frames
// instead of repeating the previous pair.
module stereo_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] in_L,
  input  logic [SAMPLE_WIDTH-1:0] in_R,
  input  logic                    in_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    sample_req,
  output logic                    overrun
);

  localparam int FRAME_W = 2 * SAMPLE_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               bclk_q, bclk_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               overrun_q, overrun_d;

  logic               div_wrap;
  logic               fall_event;
  logic               frame_load;
  logic [CNT_W-1:0]   bit_sel;

  // Bit-clock divider, bit counter, frame load and serial output selection.
  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    fall_event = div_wrap && bclk_q;
    frame_load = fall_event && (bit_cnt_q == BIT_LAST);

    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;

    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    frame_d   = frame_q;
    bit_sel   = '0;

    if (fall_event) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end

    // On underrun frame_q already holds the previous pair, so leaving it
    // untouched repeats it.
    if (frame_load) begin
      if (hold_valid_q) begin
        frame_d = hold_q;
      end else begin
`ifdef SERIALIZER_MUTE_ON_UNDERRUN_EN
        frame_d = '0;
`else
        frame_d = frame_q;
`endif
      end
    end

    // {L,R} is stored MSB first, so one index covers both slots and the
    // left MSB leaves on the same fall event that starts the frame.
    if (fall_event) begin
      bit_sel = BIT_LAST - bit_cnt_d;
      lrclk_d = (bit_cnt_d >= BIT_HALF);
      sdata_d = frame_d[bit_sel];
    end
  end

  // Holding buffer capture and sticky overrun; a load in the same cycle
  // frees the slot, so that capture is not an overwrite.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q;

    if (frame_load) begin
      hold_valid_d = 1'b0;
    end

    if (in_ready) begin
      hold_d       = {in_L, in_R};
      hold_valid_d = 1'b1;
      if (hold_valid_q && !frame_load) begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers; reset clears every output immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= BIT_LAST;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      frame_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      frame_q      <= frame_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign sample_req = frame_load;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_stereo_serializer.sv
// tb/tb_stereo_serializer.sv - self-checking bench for stereo_serializer
module tb_stereo_serializer;

  localparam int SW         = 16;
  localparam int DIV        = 2;
  localparam int FRAME_BITS = 2 * SW;
  localparam int FRAME_CLK  = 4 * SW * DIV;
  localparam int FIRST_LOAD = 2 * DIV;

`ifdef SERIALIZER_MUTE_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [SW-1:0] in_L;
  logic [SW-1:0] in_R;
  logic          in_ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          sample_req;
  logic          overrun;

  stereo_serializer #(.SAMPLE_WIDTH(SW), .BCLK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_L       (in_L),
    .in_R       (in_R),
    .in_ready   (in_ready),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .sample_req (sample_req),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame loads happen on a fixed schedule counted from reset release.
  int                    edges = 0;
  logic [FRAME_BITS-1:0] m_hold = '0;
  logic [FRAME_BITS-1:0] m_prev = '0;
  logic                  m_hv = 1'b0;
  logic                  m_ovr = 1'b0;
  logic [FRAME_BITS-1:0] exp_q[$];

  function automatic bit is_load_edge(input int e);
    return (e >= FIRST_LOAD) && (((e - FIRST_LOAD) % FRAME_CLK) == 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges  = 0;
      m_hold = '0;
      m_prev = '0;
      m_hv   = 1'b0;
      m_ovr  = 1'b0;
      exp_q.delete();
    end else begin
      bit ld;
      bit old_hv;
      edges++;
      ld     = is_load_edge(edges);
      old_hv = m_hv;
      if (ld) begin
        if (old_hv) m_prev = m_hold;
        else if (MUTE) m_prev = '0;
        exp_q.push_back(m_prev);
        m_hv = 1'b0;
      end
      if (in_ready) begin
        if (old_hv && !ld) m_ovr = 1'b1;
        m_hold = {in_L, in_R};
        m_hv   = 1'b1;
      end
    end
  end

  // Monitor: samples away from the clk edge, decodes bits on bclk rise, checks against the scoreboard.
  logic                  bclk_prev = 1'b0;
  int                    rises = 0;
  int                    frames_done = 0;
  logic [FRAME_BITS-1:0] rx = '0;
  logic [FRAME_BITS-1:0] last_frame = '0;

  always @(negedge clk) begin
    if (reset) begin
      bclk_prev = 1'b0;
      rises     = 0;
    end else begin
      chk("sample_req_timing", sample_req, is_load_edge(edges + 1));
      chk("overrun_model", overrun, m_ovr);
      if (bclk && !bclk_prev) begin
        rises++;
        if (rises > 1) begin
          int bit_i;
          bit_i = (rises - 2) % FRAME_BITS;
          chk("lrclk_slot", lrclk, bit_i >= SW);
          rx[FRAME_BITS-1-bit_i] = sdata;
          if (bit_i == FRAME_BITS - 1) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL frame_scoreboard: got %h expected <no frame queued>", rx);
            end else begin
              chk("frame_scoreboard", rx, exp_q.pop_front());
            end
            last_frame = rx;
            frames_done++;
          end
        end
      end
      bclk_prev = bclk;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    in_L     = l;
    in_R     = r;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frames_done + n;
    budget = n * (FRAME_CLK + 64);
    while (frames_done < target && budget > 0) begin
      step();
      budget--;
    end
    if (frames_done < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
    end
  endtask

  typedef struct {
    logic [SW-1:0]         in_l;
    logic [SW-1:0]         in_r;
    logic [FRAME_BITS-1:0] exp_frame;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [FRAME_BITS-1:0] repeat_pair;
    int cnt;

    tbl[0] = '{16'h1001, 16'h2001, 32'h1001_2001};
    tbl[1] = '{16'h1002, 16'h2002, 32'h1002_2002};
    tbl[2] = '{16'h1003, 16'h2003, 32'h1003_2003};
    tbl[3] = '{16'h1004, 16'h2004, 32'h1004_2004};
    repeat_pair = MUTE ? 32'h0000_0000 : 32'h7FFF_8000;

    reset    = 1'b1;
    in_ready = 1'b0;
    in_L     = '0;
    in_R     = '0;
    #1;
    chk("reset_bclk", bclk, 1'b0);
    chk("reset_lrclk", lrclk, 1'b0);
    chk("reset_sdata", sdata, 1'b0);
    chk("reset_sample_req", sample_req, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    repeat (3) step();
    reset = 1'b0;

    // Single pair captured before the first load.
    step();
    send(16'h7FFF, 16'h8000);
    wait_frames(1);
    chk("single_pair", last_frame, 32'h7FFF_8000);

    // Underrun.
    wait_frames(1);
    chk("underrun", last_frame, repeat_pair);

    // Strobe on the load cycle with holding empty.
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(is_load_edge(edges + 1) && !m_hv) && cnt < 2 * FRAME_CLK);
    chk("simul_found_load", is_load_edge(edges + 1), 1'b1);
    send(16'h5555, 16'hAAAA);
    wait_frames(1);
    chk("simul_current", last_frame, repeat_pair);
    wait_frames(1);
    chk("simul_next", last_frame, 32'h5555_AAAA);
    chk("simul_no_overrun", overrun, 1'b0);

    // Back-to-back frames, one pair per frame.
    for (int i = 0; i <= 4; i++) begin
      repeat (20) step();
      if (i < 4) send(tbl[i].in_l, tbl[i].in_r);
      wait_frames(1);
      if (i > 0) chk("b2b_frame", last_frame, tbl[i-1].exp_frame);
    end
    chk("b2b_no_overrun", overrun, 1'b0);

    // Overrun: two pairs within one frame.
    repeat (20) step();
    send(16'h1234, 16'hABCD);
    chk("overrun_first", overrun, 1'b0);
    repeat (10) step();
    send(16'h0F0F, 16'hF0F0);
    chk("overrun_set", overrun, 1'b1);
    wait_frames(2);
    chk("overrun_frame", last_frame, 32'h0F0F_F0F0);
    chk("overrun_sticky", overrun, 1'b1);

    // Reset mid-frame while the right slot drives a 1.
    cnt = 0;
    while (!(lrclk === 1'b1 && sdata === 1'b1) && cnt < 2 * FRAME_CLK) begin
      step();
      cnt++;
    end
    chk("mid_reset_found", {lrclk, sdata}, 2'b11);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_bclk", bclk, 1'b0);
    chk("mid_reset_lrclk", lrclk, 1'b0);
    chk("mid_reset_sdata", sdata, 1'b0);
    chk("mid_reset_sample_req", sample_req, 1'b0);
    chk("mid_reset_overrun", overrun, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (sample_req !== 1'b1 && cnt < 20);
    chk("first_req_cycle", cnt, FIRST_LOAD - 1);
    wait_frames(1);
    chk("post_reset_frame", last_frame, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
